// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the interrupt acknowledge decoder:
//   - default bus/channel geometry of the 27-channel controller
//   - bus code constants (A has the highest priority)
//   - FSM state encoding
//   - helpers that turn an encoded grant into a flat request index and
//     decide whether a grant code is legal
// ---------------------------------------------------------------------------
package irq_pkg;

  localparam int NUM_BUS_DEF = 3;
  localparam int NUM_CH_DEF  = 9;

  localparam logic [1:0] BUS_A = 2'd0;
  localparam logic [1:0] BUS_B = 2'd1;
  localparam logic [1:0] BUS_C = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Flat request index bus*num_ch + ch, truncated to 5 bits. Illegal codes
  // can produce indices beyond the request vector; callers must qualify the
  // result with code_legal before using it to address req/ack.
  function automatic logic [4:0] calc_idx(input logic [1:0] bus,
                                          input logic [3:0] ch,
                                          input int         num_ch);
    int sum;
    sum = int'(bus) * num_ch + int'(ch);
    return sum[4:0];
  endfunction

  function automatic logic code_legal(input logic [1:0] bus,
                                      input logic [3:0] ch,
                                      input int         num_bus,
                                      input int         num_ch);
    return (int'(bus) < num_bus) && (int'(ch) < num_ch);
  endfunction

endpackage

// File: rtl/irq_ack_decoder_if.sv
// ---------------------------------------------------------------------------
// irq_ack_decoder_if
// Encoded grant handshake between the priority controller (master) and the
// acknowledge decoder (slave).
//   grant_valid : master -> slave, encoded grant present
//   grant_bus   : master -> slave, bus code (0=A, 1=B, 2=C)
//   grant_ch    : master -> slave, channel code within the bus
//   grant_ready : slave  -> master, decoder can take a grant this cycle
// A grant transfers on a rising clock edge with grant_valid && grant_ready.
// ---------------------------------------------------------------------------
interface irq_ack_decoder_if;

  logic       grant_valid;
  logic       grant_ready;
  logic [1:0] grant_bus;
  logic [3:0] grant_ch;

  modport master (
    output grant_valid,
    output grant_bus,
    output grant_ch,
    input  grant_ready
  );

  modport slave (
    input  grant_valid,
    input  grant_bus,
    input  grant_ch,
    output grant_ready
  );

endinterface

// File: rtl/irq_ack_timer.sv
// ---------------------------------------------------------------------------
// irq_ack_timer
// Counts how long an acknowledge has been held. The count is forced to zero
// while clear is high and advances by one on each enabled cycle. terminal is
// high while the count sits at TIMEOUT-1, i.e. during the last cycle an ack
// may be held. TIMEOUT == 0 disables the terminal flag entirely.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low reset
//   clear    : synchronous clear, wins over enable
//   enable   : advance the count
//   terminal : count == TIMEOUT-1 (never set when TIMEOUT == 0)
// ---------------------------------------------------------------------------
module irq_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  // Width only needs to reach TIMEOUT-1, since the owner leaves the counting
  // state on the terminal cycle.
  localparam int CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TERM = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign terminal = 1'b0;
    end else begin : g_timeout
      assign terminal = (count == CW'(TERM));
    end
  endgenerate

endmodule

// File: rtl/irq_ack_decoder.sv
// ---------------------------------------------------------------------------
// irq_ack_decoder
// Acknowledge side of the 27-channel priority interrupt controller. Decodes
// an accepted encoded grant into a one-hot, registered acknowledge toward the
// requesting channel and holds it until that channel drops its request (or
// the hold timer expires). Illegal codes, spurious grants and timeouts are
// flagged with one-cycle pulses; completed handshakes are counted.
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset
//   host         : grant handshake (slave side: valid/bus/ch in, ready out)
//   req          : live request lines, bit index = bus*NUM_CH + ch
//   ack          : one-hot acknowledge, registered
//   busy         : high while in ACK or RELEASE
//   err_illegal  : pulse, accepted grant had bus >= NUM_BUS or ch >= NUM_CH
//   err_spurious : pulse, legal grant but the addressed request was low
//   err_timeout  : pulse, ack held TIMEOUT cycles without release
//   service_cnt  : completed handshakes, saturating
// ---------------------------------------------------------------------------
module irq_ack_decoder
  import irq_pkg::*;
#(
  parameter int NUM_BUS = NUM_BUS_DEF,
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  irq_ack_decoder_if.slave           host,
  input  logic [NUM_BUS*NUM_CH-1:0]  req,
  output logic [NUM_BUS*NUM_CH-1:0]  ack,
  output logic                       busy,
  output logic                       err_illegal,
  output logic                       err_spurious,
  output logic                       err_timeout,
  output logic [CNT_W-1:0]           service_cnt
);

  localparam int ACK_W = NUM_BUS * NUM_CH;

  state_t     state;
  state_t     state_next;
  logic [4:0] idx_q;

  logic [4:0] grant_idx;
  logic       accept;
  logic       legal;
  logic       hit;
  logic       start;
  logic       held_req;
  logic       release_now;
  logic       timeout_now;
  logic       timer_terminal;

  // Ready is the only output decoded straight from state; everything else
  // leaves the block through a flop.
  assign host.grant_ready = (state == IDLE);

  // Grant decode. hit is qualified with legal so an out-of-range index never
  // addresses the request vector.
  assign grant_idx = calc_idx(host.grant_bus, host.grant_ch, NUM_CH);
  assign legal     = code_legal(host.grant_bus, host.grant_ch, NUM_BUS, NUM_CH);
  assign accept    = host.grant_valid && (state == IDLE);
  assign hit       = legal && req[grant_idx];
  assign start     = accept && hit;

  // Only the latched channel's request matters while acknowledging; other
  // request bits are free to toggle without disturbing the ack.
  assign held_req    = req[idx_q];
  assign release_now = (state == ACK) && !held_req;
  assign timeout_now = (state == ACK) && held_req && timer_terminal;

  // Hold timer: sits at zero outside ACK so every handshake starts fresh.
  irq_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != ACK),
    .enable   (state == ACK),
    .terminal (timer_terminal)
  );

  // Next-state logic. RELEASE always lasts exactly one cycle to guarantee a
  // minimum gap between successive acknowledges.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ACK;
        end
      end
      ACK: begin
        if (release_now || timeout_now) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, latched index, registered outputs and the saturating service
  // counter. A release that coincides with the terminal timer cycle counts
  // as a normal completion because timeout_now requires the request high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx_q        <= '0;
      ack          <= '0;
      busy         <= 1'b0;
      err_illegal  <= 1'b0;
      err_spurious <= 1'b0;
      err_timeout  <= 1'b0;
      service_cnt  <= '0;
    end else begin
      state        <= state_next;
      busy         <= (state_next != IDLE);
      err_illegal  <= accept && !legal;
      err_spurious <= accept && legal && !hit;
      err_timeout  <= timeout_now;

      if (start) begin
        idx_q <= grant_idx;
        ack   <= ACK_W'(1) << grant_idx;
      end else if (release_now || timeout_now) begin
        ack <= '0;
      end

      if (release_now && (service_cnt != {CNT_W{1'b1}})) begin
        service_cnt <= service_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_irq_ack_decoder.sv
// ---------------------------------------------------------------------------
// tb_irq_ack_decoder
// Directed bench for irq_ack_decoder (TIMEOUT=8, CNT_W=2). Stimulus tasks
// push the expected output event (cycle stamp, ack vector, error pulses,
// service count) into a queue; a monitor at the falling edge pops and
// compares whenever ack changes or an error pulse is present.
// ---------------------------------------------------------------------------
module tb_irq_ack_decoder;
  import irq_pkg::*;

  localparam int NB   = 3;
  localparam int NC   = 9;
  localparam int NREQ = NB * NC;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] ack;
    logic            il;
    logic            sp;
    logic            to;
    logic [1:0]      cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic            busy;
  logic            err_illegal;
  logic            err_spurious;
  logic            err_timeout;
  logic [1:0]      service_cnt;

  irq_ack_decoder_if gif();

  irq_ack_decoder #(
    .NUM_BUS (NB),
    .NUM_CH  (NC),
    .TIMEOUT (8),
    .CNT_W   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host         (gif),
    .req          (req),
    .ack          (ack),
    .busy         (busy),
    .err_illegal  (err_illegal),
    .err_spurious (err_spurious),
    .err_timeout  (err_timeout),
    .service_cnt  (service_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int              checks = 0;
  int              errors = 0;
  exp_t            exp_q[$];
  exp_t            mon_e;
  logic [NREQ-1:0] prev_ack = '0;
  logic            mon_en = 1'b0;
  logic [1:0]      model_cnt = 2'd0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic [NREQ-1:0] a,
                          input logic il, input logic sp, input logic to,
                          input logic [1:0] cnt);
    exp_t e;
    e.cyc = c;
    e.ack = a;
    e.il  = il;
    e.sp  = sp;
    e.to  = to;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // One-cycle grant pulse starting in the current cycle.
  task automatic apply_stimulus(input logic [1:0] b, input logic [3:0] c);
    gif.grant_valid = 1'b1;
    gif.grant_bus   = b;
    gif.grant_ch    = c;
    tick(1);
    gif.grant_valid = 1'b0;
  endtask

  // Full handshake: ack is observed high for exactly 'hold' cycles, then the
  // one-cycle RELEASE gap, then ready again.
  task automatic do_service(input int b, input int c, input int hold);
    int idx;
    idx = b * NC + c;
    req[idx] = 1'b1;
    push_exp(cyc + 1, onehot(idx), 1'b0, 1'b0, 1'b0, model_cnt);
    apply_stimulus(2'(b), 4'(c));
    check_output("busy_in_ack", 32'(busy), 32'd1);
    check_output("ready_in_ack", 32'(gif.grant_ready), 32'd0);
    tick(hold - 1);
    req[idx] = 1'b0;
    model_cnt = sat_inc(model_cnt);
    push_exp(cyc + 1, '0, 1'b0, 1'b0, 1'b0, model_cnt);
    tick(1);
    check_output("ready_in_release", 32'(gif.grant_ready), 32'd0);
    tick(1);
    check_output("ready_after_release", 32'(gif.grant_ready), 32'd1);
    check_output("busy_after_release", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: any ack change or error pulse is an output event.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((ack !== prev_ack) || (err_illegal === 1'b1) ||
          (err_spurious === 1'b1) || (err_timeout === 1'b1)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_event: cyc %0d ack=%h il=%b sp=%b to=%b cnt=%0d, none expected",
                   cyc, ack, err_illegal, err_spurious, err_timeout, service_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          if ((cyc != mon_e.cyc) || (ack !== mon_e.ack) || (err_illegal !== mon_e.il) ||
              (err_spurious !== mon_e.sp) || (err_timeout !== mon_e.to) ||
              (service_cnt !== mon_e.cnt)) begin
            errors++;
            $display("[TB] FAIL event: got cyc %0d ack=%h il=%b sp=%b to=%b cnt=%0d, expected cyc %0d ack=%h il=%b sp=%b to=%b cnt=%0d",
                     cyc, ack, err_illegal, err_spurious, err_timeout, service_cnt,
                     mon_e.cyc, mon_e.ack, mon_e.il, mon_e.sp, mon_e.to, mon_e.cnt);
          end
        end
      end
      prev_ack = ack;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    req             = '0;
    gif.grant_valid = 1'b0;
    gif.grant_bus   = 2'd0;
    gif.grant_ch    = 4'd0;

    // Reset release
    #2 reset = 1'b0;
    tick(3);
    check_output("ack_in_reset", 32'(ack), 32'd0);
    reset = 1'b1;
    tick(1);
    check_output("reset_ack", 32'(ack), 32'd0);
    check_output("reset_ready", 32'(gif.grant_ready), 32'd1);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_cnt", 32'(service_cnt), 32'd0);
    check_output("reset_errs", {29'd0, err_illegal, err_spurious, err_timeout}, 32'd0);
    mon_en = 1'b1;

    // Normal service on idx 13 (bus B, ch 4)
    do_service(1, 4, 5);
    check_output("cnt_after_first", 32'(service_cnt), 32'd1);

    // Illegal and spurious codes
    push_exp(cyc + 1, '0, 1'b1, 1'b0, 1'b0, model_cnt);
    apply_stimulus(2'd3, 4'd0);
    check_output("ready_after_illegal_bus", 32'(gif.grant_ready), 32'd1);
    tick(1);
    push_exp(cyc + 1, '0, 1'b1, 1'b0, 1'b0, model_cnt);
    apply_stimulus(BUS_A, 4'd9);
    tick(1);
    push_exp(cyc + 1, '0, 1'b0, 1'b1, 1'b0, model_cnt);
    apply_stimulus(BUS_C, 4'd8);
    check_output("ready_after_spurious", 32'(gif.grant_ready), 32'd1);
    check_output("busy_after_spurious", 32'(busy), 32'd0);
    tick(1);

    // Timeout on idx 0: ack high for 8 cycles, count unchanged
    req[0] = 1'b1;
    push_exp(cyc + 1, onehot(0), 1'b0, 1'b0, 1'b0, model_cnt);
    apply_stimulus(BUS_A, 4'd0);
    push_exp(cyc + 8, '0, 1'b0, 1'b0, 1'b1, model_cnt);
    tick(7);
    check_output("ack_held_before_timeout", 32'(ack), 32'd1);
    tick(1);
    check_output("ready_after_timeout", 32'(gif.grant_ready), 32'd0);
    req[0] = 1'b0;
    tick(1);
    check_output("idle_after_timeout", 32'(gif.grant_ready), 32'd1);

    // Release in the terminal cycle wins over timeout
    do_service(0, 0, 8);

    // Busy blocking: grant to idx 19 during ACK on idx 5 is ignored
    req[5] = 1'b1;
    push_exp(cyc + 1, onehot(5), 1'b0, 1'b0, 1'b0, model_cnt);
    apply_stimulus(BUS_A, 4'd5);
    req[19]         = 1'b1;
    gif.grant_valid = 1'b1;
    gif.grant_bus   = BUS_C;
    gif.grant_ch    = 4'd1;
    tick(2);
    gif.grant_valid = 1'b0;
    check_output("ack19_blocked", 32'(ack[19]), 32'd0);
    req[5] = 1'b0;
    model_cnt = sat_inc(model_cnt);
    push_exp(cyc + 1, '0, 1'b0, 1'b0, 1'b0, model_cnt);
    tick(3);
    req[19] = 1'b0;
    check_output("cnt_after_block", 32'(service_cnt), 32'd3);

    // Reset while ack[7] is high
    req[7] = 1'b1;
    push_exp(cyc + 1, onehot(7), 1'b0, 1'b0, 1'b0, model_cnt);
    apply_stimulus(BUS_A, 4'd7);
    tick(2);
    model_cnt = 2'd0;
    push_exp(cyc, '0, 1'b0, 1'b0, 1'b0, model_cnt);
    reset = 1'b0;
    #1;
    check_output("ack_async_clear", 32'(ack), 32'd0);
    check_output("cnt_async_clear", 32'(service_cnt), 32'd0);
    req[7] = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);

    // Saturation: five services, counter stops at 3
    for (int i = 0; i < 5; i++) begin
      do_service(i % NB, i + 1, 2);
    end
    check_output("cnt_saturated", 32'(service_cnt), 32'd3);

    tick(3);
    check_output("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ack_decoder.md
Name: irq_ack_decoder

Overview:
Acknowledge side of the 27-channel priority interrupt controller. The controller issues an encoded grant made of a bus code and a channel code. This block decodes the grant into a one-hot acknowledge toward the requesting channel and holds the ack until the requester releases its request. It also flags illegal codes, spurious grants and timeouts, and counts completed services.

Parameters:
NUM_BUS, 3, number of request buses (A=0 highest priority, B=1, C=2)
NUM_CH, 9, channels per bus
TIMEOUT, 255, max cycles ack is held waiting for request release; 0 disables timeout
CNT_W, 16, width of the service counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_BUS*NUM_CH  live request lines; bit index = bus*NUM_CH+ch
grant_valid  in  1  encoded grant present
grant_ready  out  1  block can accept a grant (high only in IDLE)
grant_bus  in  2  bus code of the grant
grant_ch  in  4  channel code of the grant
ack  out  NUM_BUS*NUM_CH  one-hot acknowledge, registered
busy  out  1  high in ACK or RELEASE
err_illegal  out  1  1-cycle pulse: accepted grant had bus>=NUM_BUS or ch>=NUM_CH
err_spurious  out  1  1-cycle pulse: legal grant, but req[idx]==0
err_timeout  out  1  1-cycle pulse: ack held TIMEOUT cycles without release
service_cnt  out  CNT_W  completed handshakes, saturating

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low; it acts immediately when reset==0.
- Reset values: state=IDLE, ack=0, busy=0, grant_ready=1, all err_* =0, service_cnt=0, timer=0, latched idx=0.
- Grant acceptance: a grant is accepted on a rising edge where grant_valid && grant_ready.
- Index rule: idx = grant_bus*NUM_CH + grant_ch, computed with 5-bit width.
- States: IDLE, ACK, RELEASE.
- IDLE, on accept:
  - Illegal code: err_illegal=1 the next cycle; stay IDLE.
  - Legal code, req[idx]==0: err_spurious=1 the next cycle; stay IDLE.
  - Legal code, req[idx]==1: latch idx, timer=0, go to ACK. ack[idx] is high from the next cycle (latency 1).
- ACK:
  - ack[idx]=1, all other ack bits 0.
  - grant_valid is ignored (grant_ready=0); no err pulses are raised for ignored grants.
  - The timer increments each cycle.
  - req[idx] sampled 0: go to RELEASE; ack drops on the next cycle; service_cnt increments (saturates at all-ones).
  - TIMEOUT!=0 and timer==TIMEOUT-1 with req[idx] still 1: err_timeout pulse, ack drops, go to RELEASE; service_cnt unchanged.
  - Release and timeout in the same cycle: release wins, no err_timeout.
- RELEASE:
  - Exactly one cycle with ack=0 and grant_ready=0 (minimum gap), then IDLE.
  - Back-to-back grants therefore have at least 2 cycles between ack deassert and the next ack assert edge.
- Changes to other req bits never affect the current ack.
- Reset asserted mid-ACK: ack clears immediately (asynchronously); the handshake is abandoned and not counted.
- All outputs are registered; there are no combinational paths from inputs to outputs except grant_ready, which is decoded from the state register.

Decomposition:
- Package irq_pkg holds:
  - state enum {IDLE, ACK, RELEASE};
  - NUM_BUS/NUM_CH defaults;
  - bus code constants BUS_A=0, BUS_B=1, BUS_C=2;
  - an idx-compute function.
- One sub-module, irq_ack_timer: clear/enable counter with a terminal-count flag, parameterised by TIMEOUT. The FSM, decode and service counter stay in the top.

Test Plan:
1. Reset release: hold reset=0 for 3 cycles, then set 1 -> ack=0, grant_ready=1, service_cnt=0, all err_* =0.
2. Normal service: set req[13]=1; grant bus=1 ch=4 for one cycle -> ack[13]=1 next cycle, busy=1. Drop req[13] 5 cycles later -> ack=0 one cycle after, grant_ready=1 two cycles after, service_cnt=1.
3. Illegal/spurious: grant bus=3 ch=0 -> err_illegal pulse, ack stays 0. Grant bus=0 ch=9 -> err_illegal. Grant bus=2 ch=8 with req[26]=0 -> err_spurious, state stays IDLE.
4. Timeout: TIMEOUT=8, req[0] held 1, grant bus=0 ch=0 -> ack[0] high exactly 8 cycles, err_timeout pulse, service_cnt unchanged. Release in the 8th cycle instead -> no err_timeout, count+1.
5. Busy blocking: during ACK on idx 5, drive grant bus=2 ch=1 with req[19]=1 -> ignored, ack[19] never asserts, no err pulses.
6. Reset mid-ACK plus saturation: assert reset while ack[7]=1 -> ack=0 immediately, service_cnt=0. With CNT_W=2, run 5 services -> service_cnt stays 3.
